ascii_number_parser: RTL and testbench

- Sequencing controller for ASCII decimal input. Consumes a byte stream one character per cycle and accumulates a multi-digit number.
- Uses per-digit decode of '0'..'9' with value = value*10 + digit, then emits a binary result with an error flag.
- Sits between the UART/console receive path and the command/register logic. It replaces ad-hoc combinational chains of per-position ASCII decoders.

---
 rtl/ascii_number_parser.sv | 180 ++++++++++++++++++
 tb/tb_ascii_number_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_number_parser.sv
// ASCII decimal number parser: accumulates '0'..'9' characters into a binary value
// and emits one result per terminator. Optional negative numbers: ASCII_PARSE_SIGN_EN.

module ascii_number_parser #(
    parameter int WIDTH      = 20,
    parameter int MAX_DIGITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_error,
    output logic             out_valid,
    input  logic             out_ready
);

    // state | meaning
    // IDLE  | skipping whitespace, waiting for the first character of a number
    // ACCUM | accumulating digits
    // FLUSH | bad character or overflow seen, discarding until a terminator
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int            CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
`ifdef ASCII_PARSE_SIGN_EN
    logic             sign_q, sign_d;
    logic             is_minus;
`endif

    logic             is_digit;
    logic             is_term;
    logic             accept;
    logic             acc_ovf;
    logic [WIDTH+3:0] acc_x10;
    logic [WIDTH-1:0] term_val;
    logic             term_err;

    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_term  = (in_data == 8'h0D) || (in_data == 8'h0A) || (in_data == 8'h20);
    assign accept   = in_valid && (state_q != S_DONE);
`ifdef ASCII_PARSE_SIGN_EN
    assign is_minus = (in_data == 8'h2D);
`endif

    // acc*10 + digit, with four guard bits to catch a carry out of WIDTH
    assign acc_x10 = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                   + {{WIDTH{1'b0}}, in_data[3:0]};
    assign acc_ovf = |acc_x10[WIDTH+3:WIDTH];

    always_comb begin
`ifdef ASCII_PARSE_SIGN_EN
        term_err = sign_q && (cnt_q == '0);
        if (term_err) begin
            term_val = '0;
        end else if (sign_q) begin
            term_val = -acc_q;
        end else begin
            term_val = acc_q;
        end
`else
        term_err = 1'b0;
        term_val = acc_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
`ifdef ASCII_PARSE_SIGN_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            err_q   <= err_d;
`ifdef ASCII_PARSE_SIGN_EN
            sign_q  <= sign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        err_d   = err_q;
`ifdef ASCII_PARSE_SIGN_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = {{(WIDTH-4){1'b0}}, in_data[3:0]};
                        cnt_d   = CNT_ONE;
                        state_d = S_ACCUM;
                    end
`ifdef ASCII_PARSE_SIGN_EN
                    else if (is_minus) begin
                        sign_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end
`endif
                    else if (!is_term) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        if ((cnt_q == CNT_MAX) || acc_ovf) begin
                            state_d = S_FLUSH;
                        end else begin
                            acc_d = acc_x10[WIDTH-1:0];
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (is_term) begin
                        val_d   = term_val;
                        err_d   = term_err;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (accept && is_term) begin
                    val_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef ASCII_PARSE_SIGN_EN
                    sign_d  = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // handshake flags are pure decodes of the registered state
    always_comb begin
        in_ready  = (state_q != S_DONE);
        out_valid = (state_q == S_DONE);
        out_value = val_q;
        out_error = err_q;
    end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Randomized bench for ascii_number_parser: a line-level reference model turns the
// character stream into expected results, checked at every output transfer.

module tb_ascii_number_parser;

    localparam int W  = 20;
    localparam int MD = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_value;
    logic         out_error;
    logic         out_valid;
    logic         out_ready;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] exp_val_q[$];
    logic         exp_err_q[$];
    logic [7:0]   run_q[$];

    int           rdy_mode = 0;
    bit           mon_en   = 1'b0;
    bit           held     = 1'b0;
    logic [W-1:0] held_val;
    logic         held_err;

    always #5 clk = ~clk;

    ascii_number_parser #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_error (out_error),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One number = a maximal run of non-terminator characters
    task automatic eval_run(output logic [W-1:0] v, output logic e);
        longint acc   = 0;
        int     start = 0;
        int     nd;
        bit     neg   = 1'b0;
        e = 1'b0;
`ifdef ASCII_PARSE_SIGN_EN
        if (run_q[0] == 8'h2D) begin
            neg   = 1'b1;
            start = 1;
        end
`endif
        nd = run_q.size() - start;
        if (nd == 0 || nd > MD) e = 1'b1;
        for (int i = start; i < run_q.size(); i++) begin
            if (run_q[i] inside {[8'h30:8'h39]}) acc = acc * 10 + (longint'(run_q[i]) - 48);
            else e = 1'b1;
        end
        if (acc > (longint'(1) << W) - 1) e = 1'b1;
        if (e) v = '0;
        else if (neg) v = W'(-acc);
        else v = W'(acc);
    endtask

    task automatic model_char(input logic [7:0] c);
        logic [W-1:0] v;
        logic         e;
        if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
            if (run_q.size() > 0) begin
                eval_run(v, e);
                exp_val_q.push_back(v);
                exp_err_q.push_back(e);
                run_q.delete();
            end
        end else begin
            run_q.push_back(c);
        end
    endtask

    task automatic send(input logic [7:0] c, input int gap);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        model_char(c);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap_max);
        for (int i = 0; i < s.len(); i++) send(s[i], $urandom_range(0, gap_max));
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (held) begin
                check("hold_value", 32'(out_value), 32'(held_val));
                check("hold_error", 32'(out_error), 32'(held_err));
            end
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            if (out_valid && out_ready) begin
                if (exp_val_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 0);
                end else begin
                    check("result_value", 32'(out_value), 32'(exp_val_q[0]));
                    check("result_error", 32'(out_error), 32'(exp_err_q[0]));
                    void'(exp_val_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
            held     = out_valid && !out_ready;
            held_val = out_value;
            held_err = out_error;
        end else begin
            out_ready = 1'b0;
            held      = 1'b0;
        end
    end

    initial begin
        int         n;
        int         len;
        int         t;
        logic [7:0] c;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid",   32'(out_valid), 0);
        check("rst_inready", 32'(in_ready),  1);
        check("rst_value",   32'(out_value), 0);
        check("rst_error",   32'(out_error), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // "42\r" with latency and in_ready timing
        rdy_mode = 1;
        send(8'h34, 0);
        send(8'h32, 0);
        send(8'h0D, 0);
        @(negedge clk);
        check("lat_valid",   32'(out_valid), 1);
        check("lat_inready", 32'(in_ready),  0);
        check("lat_value",   32'(out_value), 'h2A);
        check("lat_error",   32'(out_error), 0);
        @(negedge clk);
        check("lat_valid_drop",   32'(out_valid), 0);
        check("lat_inready_back", 32'(in_ready),  1);

        send_str("  007 ", 0);
        send_str("999999", 0);
        send(8'h0D, 0);
        send_str("1000000", 0);
        send(8'h0D, 0);
        send_str("1A3", 0);
        send(8'h0D, 0);
        send_str("5\n", 0);
        send_str("\n\n  ", 0);

        // result held with out_ready low while '8' waits at the source
        rdy_mode = 2;
        send_str("12", 0);
        send(8'h0D, 0);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h38;
            check("hold_inready", 32'(in_ready),  0);
            check("hold_valid",   32'(out_valid), 1);
            check("hold_val12",   32'(out_value), 12);
        end
        rdy_mode = 1;
        send(8'h38, 0);
        send(8'h0D, 0);

        // reset mid-number discards the partial digits
        send_str("12", 0);
        @(negedge clk);
        reset = 1'b1;
        run_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst2_valid",   32'(out_valid), 0);
        check("rst2_inready", 32'(in_ready),  1);
        send_str("3", 0);
        send(8'h0D, 0);

`ifdef ASCII_PARSE_SIGN_EN
        send_str("-15", 0);
        send(8'h0D, 0);
        send_str("-", 0);
        send(8'h0D, 0);
`endif

        rdy_mode = 0;
        repeat (300) begin
            n = $urandom_range(0, 2);
            repeat (n) send(8'h20, $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) send(8'h2D, $urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) c = 8'($urandom_range(0, 255));
                else c = 8'(8'h30 + $urandom_range(0, 9));
                send(c, $urandom_range(0, 2));
            end
            case ($urandom_range(0, 2))
                0:       c = 8'h0D;
                1:       c = 8'h0A;
                default: c = 8'h20;
            endcase
            send(c, $urandom_range(0, 2));
        end

        t = 0;
        while (exp_val_q.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("pending_results", 32'(exp_val_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
